// File: rtl/hazard_control.sv
// Hazard unit: load-use and mult/div interlocks, branch flush,
// and a saturating stall-cycle counter.
module hazard_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IfIdRegRs,
  input  logic [4:0]  IfIdRegRt,
  input  logic        IfIdUsesRt,
  input  logic [4:0]  IdExRegRt,
  input  logic        IdExMemRead,
  input  logic        BranchTaken,
  input  logic        IfIdMdOp,
  input  logic        IfIdMdIsDiv,
  input  logic        IfIdMdRead,
  output logic        PcWrite,
  output logic        IfIdWrite,
  output logic        IfIdFlush,
  output logic        IdExFlush,
  output logic        MdIssue,
  output logic        MdBusy,
  output logic [15:0] StallCycles
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state;
  logic [4:0] md_cnt;
  logic       load_use;
  logic       md_hazard;
  logic       stall;
  logic       rs_hit;
  logic       rt_hit;

  assign rs_hit = (IdExRegRt == IfIdRegRs);
  assign rt_hit = IfIdUsesRt && (IdExRegRt == IfIdRegRt);

  assign load_use = IdExMemRead && (IdExRegRt != 5'd0)
                    && (rs_hit || rt_hit);

  assign md_hazard = (state == BUSY)
                     && (IfIdMdOp || IfIdMdRead);

  // Branch wins outright, so stall is made exclusive with it.
  assign stall = !BranchTaken && (load_use || md_hazard);

  assign MdBusy = (state == BUSY);

  always_comb begin
    PcWrite   = 1'b1;
    IfIdWrite = 1'b1;
    IfIdFlush = 1'b0;
    IdExFlush = 1'b0;
    MdIssue   = 1'b0;
    unique case (1'b1)
      BranchTaken: begin
        IfIdFlush = 1'b1;
        IdExFlush = 1'b1;
      end
      stall: begin
        PcWrite   = 1'b0;
        IfIdWrite = 1'b0;
        IdExFlush = 1'b1;
      end
      default: begin
        MdIssue = (state == IDLE) && IfIdMdOp;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      md_cnt <= 5'd0;
    end else if (MdIssue) begin
      state  <= BUSY;
      md_cnt <= IfIdMdIsDiv ? 5'd31 : 5'd3;
    end else if (state == BUSY) begin
      if (md_cnt != 5'd0) begin
        md_cnt <= md_cnt - 5'd1;
      end else begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCycles <= 16'd0;
    end else if (!PcWrite && (StallCycles != 16'hFFFF)) begin
      StallCycles <= StallCycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control with immediate-assertion checks.
module tb_hazard_control;

  logic        clk;
  logic        rst_n;
  logic [4:0]  IfIdRegRs;
  logic [4:0]  IfIdRegRt;
  logic        IfIdUsesRt;
  logic [4:0]  IdExRegRt;
  logic        IdExMemRead;
  logic        BranchTaken;
  logic        IfIdMdOp;
  logic        IfIdMdIsDiv;
  logic        IfIdMdRead;
  logic        PcWrite;
  logic        IfIdWrite;
  logic        IfIdFlush;
  logic        IdExFlush;
  logic        MdIssue;
  logic        MdBusy;
  logic [15:0] StallCycles;

  int checks;
  int failures;

  hazard_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IfIdRegRs   (IfIdRegRs),
    .IfIdRegRt   (IfIdRegRt),
    .IfIdUsesRt  (IfIdUsesRt),
    .IdExRegRt   (IdExRegRt),
    .IdExMemRead (IdExMemRead),
    .BranchTaken (BranchTaken),
    .IfIdMdOp    (IfIdMdOp),
    .IfIdMdIsDiv (IfIdMdIsDiv),
    .IfIdMdRead  (IfIdMdRead),
    .PcWrite     (PcWrite),
    .IfIdWrite   (IfIdWrite),
    .IfIdFlush   (IfIdFlush),
    .IdExFlush   (IdExFlush),
    .MdIssue     (MdIssue),
    .MdBusy      (MdBusy),
    .StallCycles (StallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    IfIdRegRs   = 5'd0;
    IfIdRegRt   = 5'd0;
    IfIdUsesRt  = 1'b0;
    IdExRegRt   = 5'd0;
    IdExMemRead = 1'b0;
    BranchTaken = 1'b0;
    IfIdMdOp    = 1'b0;
    IfIdMdIsDiv = 1'b0;
    IfIdMdRead  = 1'b0;
  endtask

  // {PcWrite, IfIdWrite, IfIdFlush, IdExFlush, MdIssue}
  function automatic logic [15:0] ctl();
    return {11'd0, PcWrite, IfIdWrite, IfIdFlush, IdExFlush, MdIssue};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clear_in();
    tick();
    tick();
    chk("rst_busy", {15'd0, MdBusy}, 16'd0);
    chk("rst_stall", StallCycles, 16'd0);
    chk("rst_ctl", ctl(), 16'b11000);
    rst_n = 1'b1;
    tick();

    // load-use on rs
    IdExMemRead = 1'b1;
    IdExRegRt   = 5'd5;
    IfIdRegRs   = 5'd5;
    #1;
    chk("lu_ctl", ctl(), 16'b00010);
    tick();
    chk("lu_cnt", StallCycles, 16'd1);
    IdExRegRt = 5'd0;
    IfIdRegRs = 5'd0;
    #1;
    chk("lu_r0_ctl", ctl(), 16'b11000);
    tick();
    chk("lu_r0_cnt", StallCycles, 16'd1);

    // rt qualification
    IdExRegRt  = 5'd7;
    IfIdRegRt  = 5'd7;
    IfIdRegRs  = 5'd3;
    IfIdUsesRt = 1'b0;
    #1;
    chk("rt_off_ctl", ctl(), 16'b11000);
    IfIdUsesRt = 1'b1;
    #1;
    chk("rt_on_ctl", ctl(), 16'b00010);
    tick();
    chk("rt_cnt", StallCycles, 16'd2);
    clear_in();

    // multiply then MFHI
    IfIdMdOp = 1'b1;
    #1;
    chk("mul_issue", ctl(), 16'b11001);
    chk("mul_pre_busy", {15'd0, MdBusy}, 16'd0);
    tick();
    IfIdMdOp   = 1'b0;
    IfIdMdRead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mul_busy%0d", i), {15'd0, MdBusy}, 16'd1);
      chk($sformatf("mfhi_stall%0d", i), ctl(), 16'b00010);
      tick();
    end
    chk("mul_done", {15'd0, MdBusy}, 16'd0);
    chk("mfhi_go", ctl(), 16'b11000);
    chk("mul_cnt", StallCycles, 16'd6);
    clear_in();
    tick();

    // divide then back-to-back multiply
    rst_n = 1'b0;
    #1;
    chk("rst2_cnt", StallCycles, 16'd0);
    rst_n = 1'b1;
    tick();
    IfIdMdOp    = 1'b1;
    IfIdMdIsDiv = 1'b1;
    #1;
    chk("div_issue", ctl(), 16'b11001);
    tick();
    IfIdMdIsDiv = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk($sformatf("div_busy%0d", i), {15'd0, MdBusy}, 16'd1);
      chk($sformatf("div_stall%0d", i), ctl(), 16'b00010);
      tick();
    end
    chk("div_done", {15'd0, MdBusy}, 16'd0);
    chk("mul2_issue", ctl(), 16'b11001);
    chk("div_cnt", StallCycles, 16'd32);
    tick();
    chk("mul2_busy", {15'd0, MdBusy}, 16'd1);

    // branch during BUSY flushes but does not abort
    IfIdMdOp    = 1'b0;
    IfIdMdRead  = 1'b1;
    BranchTaken = 1'b1;
    #1;
    chk("br_busy_ctl", ctl(), 16'b11110);
    tick();
    clear_in();
    chk("br_busy2", {15'd0, MdBusy}, 16'd1);
    tick();
    chk("br_busy3", {15'd0, MdBusy}, 16'd1);
    tick();
    chk("br_busy4", {15'd0, MdBusy}, 16'd1);
    tick();
    chk("br_idle", {15'd0, MdBusy}, 16'd0);
    chk("br_cnt", StallCycles, 16'd32);

    // branch + load-use + md op in IDLE
    BranchTaken = 1'b1;
    IdExMemRead = 1'b1;
    IdExRegRt   = 5'd9;
    IfIdRegRs   = 5'd9;
    IfIdMdOp    = 1'b1;
    #1;
    chk("sim_ctl", ctl(), 16'b11110);
    tick();
    chk("sim_state", {15'd0, MdBusy}, 16'd0);
    chk("sim_cnt", StallCycles, 16'd32);
    clear_in();

    // reset in the middle of a divide
    IfIdMdOp    = 1'b1;
    IfIdMdIsDiv = 1'b1;
    #1;
    chk("div3_issue", ctl(), 16'b11001);
    tick();
    IfIdMdOp    = 1'b0;
    IfIdMdIsDiv = 1'b0;
    IfIdMdRead  = 1'b1;
    repeat (9) tick();
    chk("div3_busy10", {15'd0, MdBusy}, 16'd1);
    chk("div3_cnt", StallCycles, 16'd41);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {15'd0, MdBusy}, 16'd0);
    chk("mid_rst_cnt", StallCycles, 16'd0);
    clear_in();
    IfIdMdOp = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_issue", ctl(), 16'b11001);
    tick();
    chk("post_rst_busy", {15'd0, MdBusy}, 16'd1);
    clear_in();
    repeat (4) tick();
    chk("post_rst_idle", {15'd0, MdBusy}, 16'd0);

    // saturation
    IdExMemRead = 1'b1;
    IdExRegRt   = 5'd4;
    IfIdRegRs   = 5'd4;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_cnt", StallCycles, 16'hFFFF);
    tick();
    chk("sat_hold", StallCycles, 16'hFFFF);
    clear_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port IfIdRegRs, input, 5 bits: rs field of the instruction in IF/ID.
REQ-004 SHALL have port IfIdRegRt, input, 5 bits: rt field of the instruction in IF/ID.
REQ-005 SHALL have port IfIdUsesRt, input, 1 bit: the IF/ID instruction reads rt as a source.
REQ-006 SHALL have port IdExRegRt, input, 5 bits: destination rt of the instruction in ID/EX.
REQ-007 SHALL have port IdExMemRead, input, 1 bit: the ID/EX instruction is a load.
REQ-008 SHALL have port BranchTaken, input, 1 bit: branch or jump resolved taken in EX this cycle.
REQ-009 SHALL have port IfIdMdOp, input, 1 bit: the IF/ID instruction is MULT/MULTU/DIV/DIVU.
REQ-010 SHALL have port IfIdMdIsDiv, input, 1 bit: qualifies IfIdMdOp; 1 = divide.
REQ-011 SHALL have port IfIdMdRead, input, 1 bit: the IF/ID instruction is MFHI/MFLO.
REQ-012 SHALL have ports PcWrite and IfIdWrite, outputs, 1 bit each: enable updates of PC and of the IF/ID register.
REQ-013 SHALL have ports IfIdFlush and IdExFlush, outputs, 1 bit each: zero IF/ID; insert a bubble into ID/EX.
REQ-014 SHALL have port MdIssue, output, 1 bit: one-cycle start pulse to the mult/div unit.
REQ-015 SHALL have port MdBusy, output, 1 bit: the mult/div unit is occupied.
REQ-016 SHALL have port StallCycles, output, 16 bits: count of stalled cycles.

Function
REQ-017 SHALL implement two states, IDLE and BUSY, plus a 5-bit down-counter MdCnt.
REQ-018 SHALL detect LoadUse when IdExMemRead=1, IdExRegRt!=0, and IdExRegRt equals IfIdRegRs or (IfIdUsesRt=1 and IdExRegRt equals IfIdRegRt).
REQ-019 SHALL detect MdHazard when state=BUSY and (IfIdMdOp=1 or IfIdMdRead=1).
REQ-020 SHALL apply this priority: BranchTaken, then LoadUse, then MdHazard.
REQ-021 SHALL, when BranchTaken=1, output PcWrite=1, IfIdWrite=1, IfIdFlush=1, IdExFlush=1, MdIssue=0, regardless of the other hazards.
REQ-022 SHALL, when LoadUse or MdHazard applies without BranchTaken, output PcWrite=0, IfIdWrite=0, IdExFlush=1, IfIdFlush=0, MdIssue=0.
REQ-023 SHALL otherwise output PcWrite=1, IfIdWrite=1, IfIdFlush=0, IdExFlush=0.
REQ-024 SHALL assert MdIssue combinationally when state=IDLE, IfIdMdOp=1, and there is no BranchTaken or LoadUse.
REQ-025 SHALL, on the edge where MdIssue=1, enter BUSY and load MdCnt with 31 if IfIdMdIsDiv=1, else 3.
REQ-026 SHALL, in BUSY, decrement MdCnt each cycle while MdCnt!=0, and return to IDLE on the edge after a cycle with MdCnt=0.
REQ-027 SHALL thereby hold BUSY for exactly 4 cycles (multiply) or 32 cycles (divide).
REQ-028 SHALL drive MdBusy=1 exactly while state=BUSY, including the final cycle where MdCnt=0.
REQ-029 SHALL stall a second md op or MFHI/MFLO through the final BUSY cycle, with issue or proceed occurring in the first IDLE cycle.
REQ-030 SHALL let a BranchTaken during BUSY flush the pipeline without aborting the in-flight md op; BUSY continues to count.
REQ-031 SHALL make all outputs except StallCycles and MdBusy combinational from the inputs and the current state.
REQ-032 SHALL increment StallCycles on each edge where PcWrite=0, saturating at 16'hFFFF with no wrap.

Reset
REQ-033 SHALL, while rst_n=0, immediately force state=IDLE, MdCnt=0, StallCycles=0, MdBusy=0.
REQ-034 SHALL, when reset is asserted mid-BUSY, abort the md op; after release MdIssue may fire on the first active edge.

Verification
REQ-035 SHALL pass load-use: IdExMemRead=1, IdExRegRt=5, IfIdRegRs=5 -> PcWrite=0, IfIdWrite=0, IdExFlush=1, StallCycles +1; with IdExRegRt=0 -> no stall.
REQ-036 SHALL pass rt qualification: IdExRegRt=7, IfIdRegRt=7, IfIdUsesRt=0 -> no stall; IfIdUsesRt=1 -> stall.
REQ-037 SHALL pass multiply: IfIdMdOp=1, IfIdMdIsDiv=0 in IDLE -> MdIssue pulse once, MdBusy=1 for exactly 4 cycles; an MFHI in IF/ID stalls 4 cycles, then proceeds.
REQ-038 SHALL pass divide back-to-back: DIV then MULT -> MdBusy high 32 cycles, MULT issued in the first IDLE cycle, StallCycles=32.
REQ-039 SHALL pass simultaneous events: BranchTaken=1 with LoadUse=1 and IfIdMdOp=1 -> PcWrite=1, both flushes=1, MdIssue=0, state unchanged.
REQ-040 SHALL pass reset and saturation: rst_n low at BUSY cycle 10 -> MdBusy=0 at once, StallCycles=0; 70000 forced stall cycles -> StallCycles=16'hFFFF.
